// File: rtl/btn_move_conditioner_if.sv
// Pin-side and player-side signals of the button move conditioner.
// slave: conditioner view (raw buttons in, move strobes and levels out); master: the opposite side.
interface btn_move_conditioner_if;
    logic       btnU_in;
    logic       btnD_in;
    logic       btnR_in;
    logic       btnL_in;
    logic       btnU;
    logic       btnD;
    logic       btnR;
    logic       btnL;
    logic [3:0] btn_level;

    modport master (
        output btnU_in, btnD_in, btnR_in, btnL_in,
        input  btnU, btnD, btnR, btnL, btn_level
    );

    modport slave (
        input  btnU_in, btnD_in, btnR_in, btnL_in,
        output btnU, btnD, btnR, btnL, btn_level
    );
endinterface

// File: rtl/btn_move_conditioner.sv
// Button front end: 2-FF sync, debounce, press queue, one spaced move pulse at a time.
// Ports: clk, rst_n (sync, active low), bus (slave): btn*_in raw in; btnU/D/R/L pulses, btn_level {U,D,R,L}.
// Optional auto-repeat while held: define BTN_REPEAT_EN.
module btn_move_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 18,
    parameter int MOVE_GAP        = 4,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 12500000
) (
    input logic                    clk,
    input logic                    rst_n,
    btn_move_conditioner_if.slave  bus
);

    if (DEBOUNCE_CYCLES < 1 || (2 ** DB_W) <= DEBOUNCE_CYCLES || MOVE_GAP < 0 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("btn_move_conditioner: illegal parameter set");
    end

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // GAP state lasts MOVE_GAP-1 cycles; IDLE supplies the last idle cycle.
    localparam int GW = (MOVE_GAP > 2) ? $clog2(MOVE_GAP - 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((MOVE_GAP > 1) ? MOVE_GAP - 2 : 0);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        GAP
    } state_t;

    function automatic logic [3:0] pick_hi(input logic [3:0] v);
        if (v[3])      return 4'b1000;
        else if (v[2]) return 4'b0100;
        else if (v[1]) return 4'b0010;
        else if (v[0]) return 4'b0001;
        else           return 4'b0000;
    endfunction

    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      level;
    logic [DB_W-1:0] db_cnt [4];
    logic [3:0]      accept;
    logic [3:0]      rise;
    logic [3:0]      pending;
    logic [3:0]      rep_set;
    logic [3:0]      clr;

    state_t          state;
    state_t          state_n;
    logic [GW-1:0]   gap_cnt;
    logic [GW-1:0]   gap_n;
    logic [3:0]      move;
    logic [3:0]      move_n;

    // accept: this edge the synchronised value has differed long enough.
    always_comb begin
        accept = '0;
        for (int i = 0; i < 4; i++) begin
            accept[i] = (sync2[i] != level[i]) && (db_cnt[i] == DB_LAST);
        end
        rise = accept & sync2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {bus.btnU_in, bus.btnD_in, bus.btnR_in, bus.btnL_in};
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (accept[i]) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else if (sync2[i] != level[i]) begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_nxt;
    logic [RW-1:0] rep_lim;
    logic          rep_first;
    logic          rep_hit;
    logic [3:0]    held_sel;

    // One counter follows the top-priority held button; any level change restarts it.
    always_comb begin
        held_sel = pick_hi(level);
        rep_nxt  = rep_cnt + 1'b1;
        rep_lim  = rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD);
        rep_hit  = !(|accept) && (|held_sel) && (rep_nxt >= rep_lim);
        rep_set  = rep_hit ? held_sel : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (|accept) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (|held_sel) begin
            if (rep_hit) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt   <= rep_nxt;
            end
        end
    end
`else
    assign rep_set = 4'b0000;
`endif

    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        move_n  = '0;
        clr     = '0;
        unique case (state)
            IDLE: begin
                if (|pending) begin
                    clr     = pick_hi(pending);
                    move_n  = clr;
                    state_n = FIRE;
                end
            end
            FIRE: begin
                if (MOVE_GAP <= 1) begin
                    state_n = IDLE;
                end else begin
                    state_n = GAP;
                    gap_n   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            gap_cnt <= '0;
            move    <= '0;
            pending <= '0;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_n;
            move    <= move_n;
            pending <= (pending & ~clr) | rise | rep_set;
        end
    end

    assign bus.btnU      = move[3];
    assign bus.btnD      = move[2];
    assign bus.btnR      = move[1];
    assign bus.btnL      = move[0];
    assign bus.btn_level = level;

endmodule

// File: tb/tb_btn_move_conditioner.sv
// Scoreboard bench for btn_move_conditioner with a cycle-indexed reference model.
// Expected levels and pulses are queued by the stimulus side and checked by a monitor.
module tb_btn_move_conditioner;

    localparam int DB  = 4;
    localparam int DBW = 3;
    localparam int GP  = 2;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int N   = 8192;

    logic clk;
    logic rst_n;

    btn_move_conditioner_if bus ();

    btn_move_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .DB_W(DBW),
        .MOVE_GAP(GP),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ed;
        int idx;
    } pulse_t;

    pulse_t     pq[$];
    logic [3:0] lq[$];

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] samp [N];
    logic       rstv [N];
    logic [3:0] mlvl = '0;
    logic [3:0] mpend = '0;
    int         next_fire = 0;
    int         rep_base = 0;
    int         e = 0;

    // Value the second synchroniser stage holds after edge k.
    function automatic logic [3:0] s2after(input int k);
        if (k < 1) return 4'b0000;
        if (rstv[k]) return 4'b0000;
        return samp[k-1];
    endfunction

    function automatic int hi_idx(input logic [3:0] v);
        for (int b = 3; b >= 0; b--) begin
            if (v[b]) return b;
        end
        return -1;
    endfunction

    // Advance the reference by one clock edge with inputs v and reset r.
    task automatic model(input logic [3:0] v, input logic r);
        logic [3:0] chg;
        logic [3:0] s;
        bit         ok;
        int         d;
        int         i;
        e++;
        rstv[e] = !r;
        samp[e] = r ? v : 4'b0000;
        if (!r) begin
            mlvl      = '0;
            mpend     = '0;
            next_fire = e + 1;
            rep_base  = e;
        end else begin
            if (e >= next_fire && mpend != 0) begin
                i = hi_idx(mpend);
                pq.push_back('{ed: e, idx: i});
                mpend[i]  = 1'b0;
                next_fire = e + 1 + ((GP > 1) ? GP : 1);
            end
            chg = '0;
            if (e - DB >= 1) begin
                for (int b = 0; b < 4; b++) begin
                    ok = 1'b1;
                    for (int k = e - DB; k < e; k++) begin
                        s = s2after(k);
                        if (s[b] == mlvl[b]) ok = 1'b0;
                    end
                    chg[b] = ok;
                end
            end
            mlvl  = mlvl ^ chg;
            mpend = mpend | (chg & mlvl);
`ifdef BTN_REPEAT_EN
            if (chg != 0) begin
                rep_base = e;
            end else if (mlvl != 0) begin
                d = e - rep_base;
                if (d == RD - 1 || (d > RD - 1 && (d - (RD - 1)) % RP == 0)) begin
                    mpend[hi_idx(mlvl)] = 1'b1;
                end
            end
`endif
        end
        lq.push_back(mlvl);
    endtask

    task automatic cyc(input logic [3:0] v, input logic r);
        {bus.btnU_in, bus.btnD_in, bus.btnR_in, bus.btnL_in} = v;
        rst_n = r;
        model(v, r);
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        repeat (n) cyc(v, 1'b1);
    endtask

    // Monitor: compare every edge's level and every presented pulse.
    initial begin : monitor
        int         me;
        logic [3:0] p;
        logic [3:0] lv;
        pulse_t     x;
        me = 0;
        forever begin
            @(posedge clk);
            #1;
            me++;
            p = {bus.btnU, bus.btnD, bus.btnR, bus.btnL};
            if (lq.size() != 0) begin
                lv = lq.pop_front();
                vectors++;
                if (bus.btn_level !== lv) begin
                    miscompares++;
                    $display("FAIL level edge=%0d got=%b exp=%b", me, bus.btn_level, lv);
                end
            end
            vectors++;
            if ($isunknown(p) || $countones(p) > 1) begin
                miscompares++;
                $display("FAIL onehot edge=%0d got=%b exp=at most one bit", me, p);
            end
            while (pq.size() != 0 && pq[0].ed < me) begin
                x = pq.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing_pulse edge=%0d got=none exp=idx%0d at edge %0d", me, x.idx, x.ed);
            end
            if (p != 4'b0000) begin
                vectors++;
                if (pq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse edge=%0d got=%b exp=0000", me, p);
                end else begin
                    x = pq.pop_front();
                    if (x.ed != me || p !== (4'b0001 << x.idx)) begin
                        miscompares++;
                        $display("FAIL pulse edge=%0d got=%b exp=%b at edge %0d",
                                 me, p, 4'b0001 << x.idx, x.ed);
                    end
                end
            end
        end
    end

    initial begin : stim
        samp[0] = '0;
        rstv[0] = 1'b0;
        // reset with all buttons held, then priority-ordered service
        repeat (3) cyc(4'hF, 1'b0);
        hold(4'hF, 25);
        hold(4'h0, 15);
        // single clean right press, long hold
        hold(4'b0010, 40);
        hold(4'h0, 20);
        // bouncing up button never accepted
        for (int k = 0; k < 3; k++) begin
            hold(4'b1000, 2);
            hold(4'b0000, 2);
        end
        hold(4'h0, 15);
        // up and left together
        hold(4'b1001, 20);
        hold(4'h0, 20);
        // down and left together, reset during the gap after the down pulse
        hold(4'b0101, 7);
        repeat (2) cyc(4'h0, 1'b0);
        hold(4'h0, 20);
        // random presses and bounces with occasional resets
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 24) == 0) begin
                cyc(4'($urandom_range(0, 15)), 1'b0);
            end
            hold(4'($urandom_range(0, 15)), $urandom_range(1, 12));
        end
        hold(4'h0, 40);
        vectors++;
        if (pq.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_pulses got=%0d exp=0", pq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
